// File: rtl/truth_table_scanner_pkg.sv
// Shared types and helpers for the truth-table scanner: FSM states,
// binary-to-Gray coding and a population count over a minterm mask.
package truth_table_scanner_pkg;

  localparam int MAX_N     = 8;
  localparam int MAX_DEPTH = 1 << MAX_N;

  typedef logic [MAX_N:0]       wide_t;
  typedef logic [MAX_DEPTH-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    FIN
  } scan_state_t;

  // Reflected Gray code of value, limited to the low n_in bits.
  function automatic wide_t bin2gray(input wide_t value, input int n_in);
    wide_t g;
    g = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n_in) g[i] = value[i] ^ value[i+1];
    end
    return g;
  endfunction

  function automatic wide_t popcount(input vec_t v);
    wide_t c;
    c = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      c = c + wide_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/truth_table_scanner_vector_sequencer.sv
// Walks the step counter through every input vector, holding each for
// SETTLE+1 cycles, and flags the cycle on which the output is sampled.
module vector_sequencer
  import truth_table_scanner_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1,
  parameter int GRAY   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            run,
  output logic [N_IN-1:0] code,
  output logic            sample_strobe,
  output logic            last
);

  localparam int DEPTH  = 1 << N_IN;
  localparam int HOLD_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef logic [N_IN:0]     step_t;
  typedef logic [HOLD_W-1:0] hold_t;
  typedef logic [N_IN-1:0]   code_t;

  localparam step_t LAST_STEP = step_t'(DEPTH - 1);
  localparam hold_t HOLD_INIT = hold_t'(SETTLE);

  step_t step_reg, step_next;
  hold_t hold_reg, hold_next;

  assign last          = (step_reg == LAST_STEP);
  assign sample_strobe = run && (hold_reg == '0);

  generate
    if (GRAY != 0) begin : g_gray
      assign code = code_t'(bin2gray(wide_t'(step_reg), N_IN));
    end else begin : g_bin
      assign code = step_reg[N_IN-1:0];
    end
  endgenerate

  // The last vector leaves step parked; the FSM leaves APPLY on that strobe.
  always_comb begin
    step_next = step_reg;
    hold_next = hold_reg;
    if (load) begin
      step_next = '0;
      hold_next = HOLD_INIT;
    end else if (run) begin
      if (hold_reg == '0) begin
        if (!last) begin
          step_next = step_reg + step_t'(1);
          hold_next = HOLD_INIT;
        end
      end else begin
        hold_next = hold_reg - hold_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_reg <= '0;
      hold_reg <= '0;
    end else begin
      step_reg <= step_next;
      hold_reg <= hold_next;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Drives every input combination onto a function under test, captures its
// output into a minterm mask and compares it against the expected mask.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1,
  parameter int GRAY   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [(1<<N_IN)-1:0] expected,
  output logic [N_IN-1:0]      x_out,
  input  logic                 s_in,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] minterms,
  output logic                 mismatch,
  output logic [N_IN:0]        err_count
);

  localparam int DEPTH = 1 << N_IN;

  typedef logic [N_IN:0]    cnt_t;
  typedef logic [DEPTH-1:0] mask_t;

  scan_state_t state_reg, state_next;
  mask_t       expected_reg, expected_next;
  mask_t       minterms_reg, minterms_next;
  logic        mismatch_reg, mismatch_next;
  cnt_t        err_reg, err_next;

  mask_t           captured;
  logic            load;
  logic            run;
  logic [N_IN-1:0] code;
  logic            sample_strobe;
  logic            last;

  assign run = (state_reg == APPLY);

  vector_sequencer #(
    .N_IN  (N_IN),
    .SETTLE(SETTLE),
    .GRAY  (GRAY)
  ) u_seq (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .run          (run),
    .code         (code),
    .sample_strobe(sample_strobe),
    .last         (last)
  );

  // captured includes the bit being sampled this cycle, so the compare made
  // on the FIN entry edge already sees the final minterm.
  always_comb begin
    state_next    = state_reg;
    expected_next = expected_reg;
    minterms_next = minterms_reg;
    mismatch_next = mismatch_reg;
    err_next      = err_reg;
    load          = 1'b0;
    captured      = minterms_reg;
    captured[code] = s_in;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load          = 1'b1;
          expected_next = expected;
          minterms_next = '0;
          mismatch_next = 1'b0;
          err_next      = '0;
          state_next    = APPLY;
        end
      end
      APPLY: begin
        if (sample_strobe) begin
          minterms_next = captured;
          if (last) begin
            mismatch_next = |(captured ^ expected_reg);
            err_next      = cnt_t'(popcount(vec_t'(captured ^ expected_reg)));
            state_next    = FIN;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      expected_reg <= '0;
      minterms_reg <= '0;
      mismatch_reg <= 1'b0;
      err_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      expected_reg <= expected_next;
      minterms_reg <= minterms_next;
      mismatch_reg <= mismatch_next;
      err_reg      <= err_next;
    end
  end

  assign x_out     = run ? code : '0;
  assign busy      = run;
  assign done      = (state_reg == FIN);
  assign minterms  = minterms_reg;
  assign mismatch  = mismatch_reg;
  assign err_count = err_reg;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench: a binary-order and a Gray-order scanner sweep the same function mask;
// results are checked against a mask-level model of the expected scan.
module tb_truth_table_scanner;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] expected;
  logic [7:0] func;

  logic [2:0] x_b, x_g;
  logic       s_b, s_g;
  logic       busy_b, busy_g, done_b, done_g;
  logic [7:0] min_b, min_g;
  logic       mis_b, mis_g;
  logic [3:0] err_b, err_g;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] gray_seq [8];

  // The function under test is a lookup into the chosen truth-table mask.
  assign s_b = func[x_b];
  assign s_g = func[x_g];

  truth_table_scanner #(.N_IN(3), .SETTLE(1), .GRAY(0)) dut (
    .clk(clk), .reset(reset), .start(start), .expected(expected),
    .x_out(x_b), .s_in(s_b), .busy(busy_b), .done(done_b),
    .minterms(min_b), .mismatch(mis_b), .err_count(err_b)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(1), .GRAY(1)) dut_g (
    .clk(clk), .reset(reset), .start(start), .expected(expected),
    .x_out(x_g), .s_in(s_g), .busy(busy_g), .done(done_g),
    .minterms(min_g), .mismatch(mis_g), .err_count(err_g)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_x_b"}, 32'(x_b), 0);
    check({tag, "_x_g"}, 32'(x_g), 0);
    check({tag, "_busy_b"}, 32'(busy_b), 0);
    check({tag, "_busy_g"}, 32'(busy_g), 0);
    check({tag, "_done_b"}, 32'(done_b), 0);
    check({tag, "_done_g"}, 32'(done_g), 0);
    check({tag, "_min_b"}, 32'(min_b), 0);
    check({tag, "_min_g"}, 32'(min_g), 0);
    check({tag, "_mis_b"}, 32'(mis_b), 0);
    check({tag, "_err_b"}, 32'(err_b), 0);
    check({tag, "_err_g"}, 32'(err_g), 0);
  endtask

  // Called at a negedge with both DUTs idle. poke_at/reset_at give the scan
  // cycle (1..16) at which a stray start pulse or an abort is applied; 0 = none.
  task automatic run_scan(input logic [7:0] f, input logic [7:0] e,
                          input int poke_at, input int reset_at);
    logic [3:0] exp_err;
    logic       exp_mis;
    exp_err = 4'($countones(f ^ e));
    exp_mis = (f != e);
    func     = f;
    expected = e;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    expected = ~e;
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) @(negedge clk);
      start = (c == poke_at);
      if (c == reset_at) begin
        reset = 1'b1;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check("abort_nodone_b", 32'(done_b | busy_b), 0);
          check("abort_nodone_g", 32'(done_g | busy_g), 0);
        end
        $display("scan func=%02h exp=%02h aborted at cycle %0d", f, e, c);
        return;
      end
      if (c <= 16) begin
        check("x_bin", 32'(x_b), 32'((c - 1) / 2));
        check("x_gray", 32'(x_g), 32'(gray_seq[(c - 1) / 2]));
        check("busy_b", 32'(busy_b), 1);
        check("busy_g", 32'(busy_g), 1);
        check("done_early_b", 32'(done_b), 0);
        check("done_early_g", 32'(done_g), 0);
      end else begin
        check("done_b", 32'(done_b), 1);
        check("done_g", 32'(done_g), 1);
        check("fin_busy", 32'(busy_b | busy_g), 0);
        check("fin_x", 32'({x_b, x_g}), 0);
        check("min_b", 32'(min_b), 32'(f));
        check("min_g", 32'(min_g), 32'(f));
        check("mis_b", 32'(mis_b), 32'(exp_mis));
        check("mis_g", 32'(mis_g), 32'(exp_mis));
        check("err_b", 32'(err_b), 32'(exp_err));
        check("err_g", 32'(err_g), 32'(exp_err));
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("hold_done", 32'(done_b | done_g), 0);
    check("hold_min_b", 32'(min_b), 32'(f));
    check("hold_err_g", 32'(err_g), 32'(exp_err));
    $display("scan func=%02h exp=%02h min=%02h/%02h err=%0d/%0d mis=%0d/%0d",
             f, e, min_b, min_g, err_b, err_g, mis_b, mis_g);
  endtask

  initial begin
    logic [7:0] rf, re;
    gray_seq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    clk      = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    expected = 8'h00;
    func     = 8'h00;
    #3;
    check_idle_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_scan(8'h04, 8'h04, 0, 0);   // s = ~x & y & ~z, match
    run_scan(8'h04, 8'h05, 0, 0);   // one wrong bit
    run_scan(8'hAA, 8'h00, 0, 0);   // s = z, four wrong bits
    run_scan(8'h04, 8'h04, 7, 0);   // stray start at step 3
    run_scan(8'h04, 8'h04, 0, 11);  // abort at step 5
    run_scan(8'h04, 8'h04, 0, 0);   // full scan after the abort
    run_scan(8'hFF, 8'h00, 0, 0);   // every bit wrong

    for (int i = 0; i < 20; i++) begin
      rf = 8'($urandom);
      re = ($urandom_range(0, 1) == 1) ? rf : (rf ^ 8'($urandom));
      run_scan(rf, re, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
